// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush controller for a five-stage in-order pipeline. It resolves
//   load-use hazards (with a configurable number of stall cycles), branch
//   redirects resolved in execute, and memory-stage wait states. The
//   stall/flush outputs are Mealy outputs of the current state and the inputs.
//
// Parameters
//   REGISTER  register-index width
//   LOAD_LAT  stall cycles per load-use hazard (1..7)
//
// Ports
//   CLK, RST_N      clock, asynchronous active-low reset
//   RsD, RtD        decode-stage source registers
//   UsesRtD         decode instruction reads RtD
//   MemReadE        execute-stage instruction is a load
//   WriteRegE       execute-stage destination register
//   BranchTakenE    redirect resolved in execute
//   MemReqM         memory-stage access in progress
//   MemReadyM       memory-stage access completes this cycle
//   StallF/D/E      hold PC / decode / IF-EX register
//   FlushD/E        clear decode / bubble into IF-EX register
//   State           RUN=00, LOAD_STALL=01, MEM_WAIT=10
//   StallCount      saturating count of cycles with StallF=1
module pipeline_hazard_ctrl #(
  parameter int REGISTER = 6,
  parameter int LOAD_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [REGISTER-1:0] RsD,
  input  logic [REGISTER-1:0] RtD,
  input  logic                UsesRtD,
  input  logic                MemReadE,
  input  logic [REGISTER-1:0] WriteRegE,
  input  logic                BranchTakenE,
  input  logic                MemReqM,
  input  logic                MemReadyM,
  output logic                StallF,
  output logic                StallD,
  output logic                StallE,
  output logic                FlushD,
  output logic                FlushE,
  output logic [1:0]          State,
  output logic [15:0]         StallCount
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    ILLEGAL    = 2'b11
  } state_t;

  // {StallF, StallD, StallE, FlushD, FlushE}
  localparam logic [4:0] PAT_IDLE   = 5'b00000;
  localparam logic [4:0] PAT_FREEZE = 5'b11100;
  localparam logic [4:0] PAT_LOAD   = 5'b11001;
  localparam logic [4:0] PAT_BRANCH = 5'b00011;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t     state, state_nxt;
  state_t     ret, ret_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [4:0] pat;
  logic       freeze;
  logic       hazard;

  assign freeze = MemReqM & ~MemReadyM;
  assign hazard = MemReadE & (WriteRegE != '0) &
                  ((WriteRegE == RsD) | (UsesRtD & (WriteRegE == RtD)));

  always_comb begin
    pat       = PAT_IDLE;
    state_nxt = state;
    ret_nxt   = ret;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (freeze) begin
          pat       = PAT_FREEZE;
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
        end else if (BranchTakenE) begin
          pat = PAT_BRANCH;
        end else if (hazard) begin
          pat = PAT_LOAD;
          // A single-cycle stall is fully covered by this cycle.
          if (LOAD_LAT > 1) begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      LOAD_STALL: begin
        if (freeze) begin
          pat       = PAT_FREEZE;
          state_nxt = MEM_WAIT;
          ret_nxt   = LOAD_STALL;
        end else begin
          pat = PAT_LOAD;
          if (cnt == 3'd1) state_nxt = RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
      end
      MEM_WAIT: begin
        if (!MemReadyM) begin
          pat = PAT_FREEZE;
        end else if (ret == LOAD_STALL) begin
          // Completing access consumes one of the remaining load-stall cycles.
          pat = PAT_LOAD;
          if (cnt == 3'd1) state_nxt = RUN;
          else begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = cnt - 3'd1;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    // Outputs are quiet while reset is held, whatever the inputs do.
    if (!RST_N) pat = PAT_IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= RUN;
      ret        <= RUN;
      cnt        <= '0;
      StallCount <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      cnt   <= cnt_nxt;
      if (pat[4] && (StallCount != '1)) StallCount <= StallCount + 16'd1;
    end
  end

  assign {StallF, StallD, StallE, FlushD, FlushE} = pat;
  assign State = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int RW = 6;
  localparam logic [4:0] P_IDLE   = 5'b00000;
  localparam logic [4:0] P_FREEZE = 5'b11100;
  localparam logic [4:0] P_LOAD   = 5'b11001;
  localparam logic [4:0] P_BRANCH = 5'b00011;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [RW-1:0] RsD = '0, RtD = '0, WriteRegE = '0;
  logic          UsesRtD = 1'b0, MemReadE = 1'b0, BranchTakenE = 1'b0;
  logic          MemReqM = 1'b0, MemReadyM = 1'b0;

  logic          sf1, sd1, se1, fd1, fe1, sf3, sd3, se3, fd3, fe3;
  logic [4:0]    pat1, pat3;
  logic [1:0]    st1, st3;
  logic [15:0]   cnt1, cnt3;

  assign pat1 = {sf1, sd1, se1, fd1, fe1};
  assign pat3 = {sf3, sd3, se3, fd3, fe3};

  pipeline_hazard_ctrl #(.REGISTER(RW), .LOAD_LAT(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .RsD(RsD), .RtD(RtD), .UsesRtD(UsesRtD),
    .MemReadE(MemReadE), .WriteRegE(WriteRegE), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .FlushD(fd1), .FlushE(fe1),
    .State(st1), .StallCount(cnt1)
  );

  pipeline_hazard_ctrl #(.REGISTER(RW), .LOAD_LAT(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .RsD(RsD), .RtD(RtD), .UsesRtD(UsesRtD),
    .MemReadE(MemReadE), .WriteRegE(WriteRegE), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(sf3), .StallD(sd3), .StallE(se3), .FlushD(fd3), .FlushE(fe3),
    .State(st3), .StallCount(cnt3)
  );

  always #5 CLK = ~CLK;

  int cmp_n = 0;
  int bad_n = 0;

  task automatic chk(input string nm, input int got, input int exp);
    cmp_n++;
    if (got != exp) begin
      bad_n++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: rem = load-stall cycles still owed after this one, frz = waiting on memory.
  int  lat [2] = '{1, 3};
  int  m_rem [2];
  bit  m_frz [2];
  int  m_cnt [2];
  int  n_rem [2];
  bit  n_frz [2];
  bit  n_inc [2];

  function automatic void model(input int lt, input int rem, input bit frz,
                                output logic [4:0] pat, output int nrem, output bit nfrz);
    bit fz, hz;
    fz = MemReqM && !MemReadyM;
    hz = MemReadE && (WriteRegE != 0) &&
         ((WriteRegE == RsD) || (UsesRtD && (WriteRegE == RtD)));
    pat  = P_IDLE;
    nrem = rem;
    nfrz = frz;
    if (frz) begin
      if (!MemReadyM) pat = P_FREEZE;
      else begin
        nfrz = 1'b0;
        if (rem > 0) begin pat = P_LOAD; nrem = rem - 1; end
      end
    end else if (rem > 0) begin
      if (fz) begin pat = P_FREEZE; nfrz = 1'b1; end
      else begin pat = P_LOAD; nrem = rem - 1; end
    end else if (fz) begin
      pat = P_FREEZE; nfrz = 1'b1;
    end else if (BranchTakenE) begin
      pat = P_BRANCH;
    end else if (hz) begin
      pat = P_LOAD; nrem = lt - 1;
    end
  endfunction

  // Per-cycle compare of both instances against the model.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_frz[i] = 1'b0; m_cnt[i] = 0;
    end
    forever begin
      @(negedge CLK);
      #2;
      for (int i = 0; i < 2; i++) begin
        logic [4:0] ep, ap;
        int         nr, es;
        bit         nf;
        if (!RST_N) begin
          m_rem[i] = 0; m_frz[i] = 1'b0; m_cnt[i] = 0;
          ep = P_IDLE; nr = 0; nf = 1'b0;
        end else begin
          model(lat[i], m_rem[i], m_frz[i], ep, nr, nf);
        end
        ap = (i == 0) ? pat1 : pat3;
        es = m_frz[i] ? 2 : ((m_rem[i] > 0) ? 1 : 0);
        chk($sformatf("pattern_L%0d", lat[i]), int'(ap), int'(ep));
        chk($sformatf("state_L%0d", lat[i]), int'((i == 0) ? st1 : st3), es);
        chk($sformatf("count_L%0d", lat[i]), int'((i == 0) ? cnt1 : cnt3), m_cnt[i]);
        n_rem[i] = nr; n_frz[i] = nf; n_inc[i] = ep[4];
      end
      @(posedge CLK);
      if (RST_N) begin
        for (int i = 0; i < 2; i++) begin
          m_rem[i] = n_rem[i];
          m_frz[i] = n_frz[i];
          if (n_inc[i] && (m_cnt[i] < 65535)) m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_in();
    RsD = '0; RtD = '0; WriteRegE = '0; UsesRtD = 1'b0; MemReadE = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    idle_in();
    step();
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    idle_in();
    RST_N = 1'b0;
    step();
    step();
    chk("reset_state", int'(st3), 0);
    chk("reset_count", int'(cnt3), 0);
    RST_N = 1'b1;

    // Single-cycle load-use hazard on Rs.
    MemReadE = 1'b1; WriteRegE = 6'd5; RsD = 6'd5;
    #1;
    chk("lat1_load_pat", int'(pat1), int'(P_LOAD));
    step();
    idle_in();
    chk("lat1_state_run", int'(st1), 0);
    step(); step(); step();
    chk("lat1_count", int'(cnt1), 1);
    chk("lat3_count_rs", int'(cnt3), 3);

    // Hazard through Rt, then the same without UsesRtD.
    do_reset();
    MemReadE = 1'b1; WriteRegE = 6'd9; RtD = 6'd9; UsesRtD = 1'b1; RsD = 6'd2;
    step();
    idle_in();
    chk("rt_state_c1", int'(st3), 1);
    step();
    chk("rt_state_c2", int'(st3), 1);
    step();
    chk("rt_state_c3", int'(st3), 0);
    chk("rt_count", int'(cnt3), 3);
    MemReadE = 1'b1; WriteRegE = 6'd9; RtD = 6'd9; UsesRtD = 1'b0; RsD = 6'd2;
    #1;
    chk("rt_unused_pat", int'(pat3), int'(P_IDLE));
    step();
    idle_in();
    chk("rt_unused_count", int'(cnt3), 3);

    // Register zero never hazards; branch outranks hazard.
    MemReadE = 1'b1; WriteRegE = 6'd0; RsD = 6'd0;
    #1;
    chk("r0_pat", int'(pat3), int'(P_IDLE));
    step();
    MemReadE = 1'b1; WriteRegE = 6'd7; RsD = 6'd7; BranchTakenE = 1'b1;
    #1;
    chk("branch_pat_l3", int'(pat3), int'(P_BRANCH));
    chk("branch_pat_l1", int'(pat1), int'(P_BRANCH));
    step();
    idle_in();
    chk("branch_state", int'(st3), 0);

    // Memory freeze arriving on the second load-stall cycle.
    do_reset();
    MemReadE = 1'b1; WriteRegE = 6'd5; RsD = 6'd5;
    step();
    idle_in();
    chk("frz_pre_state", int'(st3), 1);
    MemReqM = 1'b1;
    step();
    chk("frz_state_wait", int'(st3), 2);
    repeat (3) step();
    MemReadyM = 1'b1;
    #1;
    chk("frz_resume_l3", int'(pat3), int'(P_LOAD));
    chk("frz_resume_l1", int'(pat1), int'(P_IDLE));
    step();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    chk("frz_state_ls", int'(st3), 1);
    step();
    chk("frz_state_run", int'(st3), 0);
    chk("frz_count", int'(cnt3), 7);

    // Asynchronous reset in the middle of a load stall.
    do_reset();
    MemReadE = 1'b1; WriteRegE = 6'd5; RsD = 6'd5;
    step();
    idle_in();
    chk("arst_pre_state", int'(st3), 1);
    MemReqM = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("arst_pat", int'(pat3), int'(P_IDLE));
    chk("arst_state", int'(st3), 0);
    chk("arst_count", int'(cnt3), 0);
    step();
    step();
    RST_N = 1'b1;
    #1;
    chk("arst_first_run", int'(pat3), int'(P_FREEZE));
    step();
    chk("arst_to_wait", int'(st3), 2);
    MemReadyM = 1'b1;
    step();
    idle_in();

    // Saturation of the stall counter.
    do_reset();
    MemReqM = 1'b1;
    repeat (65534) step();
    chk("sat_pre", int'(cnt3), 16'hFFFE);
    repeat (3) step();
    chk("sat_l3", int'(cnt3), 16'hFFFF);
    chk("sat_l1", int'(cnt1), 16'hFFFF);
    MemReadyM = 1'b1;
    step();
    idle_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
